// File: rtl/hit_pkg.sv
// rtl/hit_pkg.sv - shared descriptor layout, unpack helper and scan FSM encoding
package hit_pkg;

   localparam int MAX_COORD_W = 32;
   localparam int NUM_FIELDS = 4;
   localparam int DESC_MAXW = NUM_FIELDS * MAX_COORD_W;

   // Field positions in units of COORD_W, counted from the LSB of a descriptor word.
   localparam int FLD_BLX = 3;
   localparam int FLD_BLY = 2;
   localparam int FLD_WIDTH = 1;
   localparam int FLD_HEIGHT = 0;

   localparam int DEFAULT_SCREEN_H = 480;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } scanStateT;

   typedef struct packed {
      logic [MAX_COORD_W-1:0] blX;
      logic [MAX_COORD_W-1:0] blY;
      logic [MAX_COORD_W-1:0] width;
      logic [MAX_COORD_W-1:0] height;
   } rectT;

   function automatic logic [MAX_COORD_W-1:0] descField(input logic [DESC_MAXW-1:0] desc,
                                                         input int field, input int coordW);
      logic [MAX_COORD_W-1:0] fieldMask;
      fieldMask = (MAX_COORD_W'(1) << coordW) - MAX_COORD_W'(1);
      return MAX_COORD_W'(desc >> (field * coordW)) & fieldMask;
   endfunction

   function automatic rectT rectUnpack(input logic [DESC_MAXW-1:0] desc, input int coordW);
      rectT r;
      r.blX = descField(desc, FLD_BLX, coordW);
      r.blY = descField(desc, FLD_BLY, coordW);
      r.width = descField(desc, FLD_WIDTH, coordW);
      r.height = descField(desc, FLD_HEIGHT, coordW);
      return r;
   endfunction

endpackage

// File: rtl/rect_hit_scan_if.sv
// rtl/rect_hit_scan_if.sv - query, descriptor read port and result channel of rect_hit_scan
interface rect_hit_scan_if #(
   parameter int COORD_W = 16,
   parameter int NUM_RECTS = 8
);
   localparam int IDX_W = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1;

   logic                   query_valid;
   logic                   query_ready;
   logic [COORD_W-1:0]     query_x;
   logic [COORD_W-1:0]     query_y;
   logic                   rect_rd_en;
   logic [IDX_W-1:0]       rect_addr;
   logic [4*COORD_W-1:0]   rect_data;
   logic                   result_valid;
   logic                   result_ready;
   logic                   result_hit;
   logic [IDX_W-1:0]       result_idx;
   logic [NUM_RECTS-1:0]   result_mask;

   modport slave (
      input  query_valid, query_x, query_y, rect_data, result_ready,
      output query_ready, rect_rd_en, rect_addr, result_valid, result_hit, result_idx, result_mask
   );

   modport master (
      output query_valid, query_x, query_y, rect_data, result_ready,
      input  query_ready, rect_rd_en, rect_addr, result_valid, result_hit, result_idx, result_mask
   );
endinterface

// File: rtl/rect_contains.sv
// rtl/rect_contains.sv - combinational point-in-rectangle test against one unpacked descriptor
module rect_contains
   import hit_pkg::*;
#(
   parameter int COORD_W = 16,
   parameter bit INCLUSIVE = 1'b0
) (
   input  logic [COORD_W-1:0] pointX,
   input  logic [COORD_W-1:0] pointY,
   input  rectT               rect,
   output logic               contained
);
   logic [COORD_W:0] px, py, left, bottom, right, top;

   // One extra bit keeps bl + size from wrapping near the top of the coordinate range.
   assign px = {1'b0, pointX};
   assign py = {1'b0, pointY};
   assign left = {1'b0, rect.blX[COORD_W-1:0]};
   assign bottom = {1'b0, rect.blY[COORD_W-1:0]};
   assign right = left + {1'b0, rect.width[COORD_W-1:0]};
   assign top = bottom + {1'b0, rect.height[COORD_W-1:0]};

   if (INCLUSIVE) begin : gInclusive
      assign contained = (px >= left) && (px <= right) && (py >= bottom) && (py <= top);
   end else begin : gStrict
      assign contained = (px > left) && (px < right) && (py > bottom) && (py < top);
   end

   if (COORD_W < MAX_COORD_W) begin : gHighBits
      logic unusedHighBits;
      assign unusedHighBits = ^{rect.blX[MAX_COORD_W-1:COORD_W], rect.blY[MAX_COORD_W-1:COORD_W],
                                rect.width[MAX_COORD_W-1:COORD_W], rect.height[MAX_COORD_W-1:COORD_W]};
   end
endmodule

// File: rtl/rect_hit_scan.sv
// rtl/rect_hit_scan.sv - sequential scan of a rectangle table for one query point per handshake
module rect_hit_scan
   import hit_pkg::*;
#(
   parameter int COORD_W = 16,
   parameter int NUM_RECTS = 8,
   parameter int SCREEN_H = DEFAULT_SCREEN_H,
   parameter bit FLIP_Y = 1'b1,
   parameter bit INCLUSIVE = 1'b0
) (
   input logic clock,
   input logic resetn,
   rect_hit_scan_if.slave bus
);
   localparam int IDX_W = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1;
   localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(NUM_RECTS - 1);
   localparam logic [COORD_W-1:0] SCREEN_H_C = COORD_W'(SCREEN_H);

   scanStateT state, stateNext;
   logic [COORD_W-1:0] pointX, pointY;
   logic offScreen;
   logic rdEn;
   logic [IDX_W-1:0] rdAddr;
   logic pendValid;
   logic [IDX_W-1:0] pendIdx;
   logic [NUM_RECTS-1:0] maskAcc, hitVec, maskFinal, resMask;
   logic [IDX_W-1:0] firstHit, resIdx;
   logic resHit;
   rectT rect;
   logic contained;

   assign rect = rectUnpack(DESC_MAXW'(bus.rect_data), COORD_W);

   rect_contains #(.COORD_W(COORD_W), .INCLUSIVE(INCLUSIVE)) uContains (
      .pointX(pointX),
      .pointY(pointY),
      .rect(rect),
      .contained(contained)
   );

   // pendValid/pendIdx track the read issued last cycle, whose data is on rect_data now.
   always_comb begin
      hitVec = '0;
      if (pendValid && contained && !offScreen) hitVec[pendIdx] = 1'b1;
   end

   assign maskFinal = maskAcc | hitVec;

   always_comb begin
      firstHit = '0;
      for (int i = NUM_RECTS - 1; i >= 0; i--) begin
         if (maskFinal[i]) firstHit = IDX_W'(i);
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (bus.query_valid) stateNext = SCAN;
         SCAN:    if (rdAddr == LAST_ADDR) stateNext = DRAIN;
         DRAIN:   stateNext = DONE;
         DONE:    if (bus.result_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         pointX <= '0;
         pointY <= '0;
         offScreen <= 1'b0;
         rdEn <= 1'b0;
         rdAddr <= '0;
         pendValid <= 1'b0;
         pendIdx <= '0;
         maskAcc <= '0;
         resMask <= '0;
         resHit <= 1'b0;
         resIdx <= '0;
      end else begin
         state <= stateNext;
         pendValid <= rdEn;
         pendIdx <= rdAddr;
         case (state)
            IDLE: begin
               if (bus.query_valid) begin
                  pointX <= bus.query_x;
                  if (FLIP_Y) begin
                     offScreen <= bus.query_y > SCREEN_H_C;
                     pointY <= SCREEN_H_C - bus.query_y;
                  end else begin
                     offScreen <= 1'b0;
                     pointY <= bus.query_y;
                  end
                  maskAcc <= '0;
                  rdEn <= 1'b1;
                  rdAddr <= '0;
               end
            end
            SCAN: begin
               maskAcc <= maskFinal;
               if (rdAddr == LAST_ADDR) rdEn <= 1'b0;
               else rdAddr <= rdAddr + IDX_W'(1);
            end
            DRAIN: begin
               resMask <= maskFinal;
               resHit <= |maskFinal;
               resIdx <= firstHit;
            end
            default: ;
         endcase
      end
   end

   assign bus.query_ready = (state == IDLE);
   assign bus.result_valid = (state == DONE);
   assign bus.rect_rd_en = rdEn;
   assign bus.rect_addr = rdAddr;
   assign bus.result_mask = resMask;
   assign bus.result_hit = resHit;
   assign bus.result_idx = resIdx;
endmodule

// File: tb/tb_rect_hit_scan.sv
// tb/tb_rect_hit_scan.sv - randomized and directed bench for rect_hit_scan against a geometric model
module tb_rect_hit_scan;
   localparam int CW = 16;
   localparam int NR = 4;
   localparam int SH = 480;

   logic clock = 1'b0;
   logic resetn;
   always #5 clock = ~clock;

   rect_hit_scan_if #(.COORD_W(CW), .NUM_RECTS(NR)) busS ();
   rect_hit_scan_if #(.COORD_W(CW), .NUM_RECTS(NR)) busI ();

   rect_hit_scan #(.COORD_W(CW), .NUM_RECTS(NR), .SCREEN_H(SH), .FLIP_Y(1'b1), .INCLUSIVE(1'b0)) dutS (
      .clock(clock), .resetn(resetn), .bus(busS));
   rect_hit_scan #(.COORD_W(CW), .NUM_RECTS(NR), .SCREEN_H(SH), .FLIP_Y(1'b1), .INCLUSIVE(1'b1)) dutI (
      .clock(clock), .resetn(resetn), .bus(busI));

   assign busI.query_valid = busS.query_valid;
   assign busI.query_x = busS.query_x;
   assign busI.query_y = busS.query_y;
   assign busI.result_ready = busS.result_ready;

   int rBlX[NR], rBlY[NR], rW[NR], rH[NR];
   int checks = 0;
   int failures = 0;
   int cyc = 0;

   function automatic logic [4*CW-1:0] packRect(input int i);
      return {CW'(rBlX[i]), CW'(rBlY[i]), CW'(rW[i]), CW'(rH[i])};
   endfunction

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (busS.rect_rd_en) busS.rect_data <= packRect(int'(busS.rect_addr));
      if (busI.rect_rd_en) busI.rect_data <= packRect(int'(busI.rect_addr));
   end

   // Geometric reference: flip y to y-up, then plain integer interval tests.
   function automatic logic [NR-1:0] modelMask(input int x, input int y, input bit incl);
      logic [NR-1:0] m = '0;
      int yy;
      if (y > SH) return '0;
      yy = SH - y;
      for (int i = 0; i < NR; i++) begin
         if (incl)
            m[i] = (x >= rBlX[i]) && (x <= rBlX[i] + rW[i]) && (yy >= rBlY[i]) && (yy <= rBlY[i] + rH[i]);
         else
            m[i] = (x > rBlX[i]) && (x < rBlX[i] + rW[i]) && (yy > rBlY[i]) && (yy < rBlY[i] + rH[i]);
      end
      return m;
   endfunction

   function automatic int lowestIdx(input logic [NR-1:0] m);
      for (int i = 0; i < NR; i++) if (m[i]) return i;
      return 0;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare process: tracks each accepted query and checks every cycle it matters.
   bit active = 1'b0;
   bit seenResult = 1'b0;
   int t0 = 0;
   int readCnt = 0;
   logic [NR-1:0] expS, expI;

   always @(negedge clock) begin
      if (resetn !== 1'b1) begin
         active = 1'b0;
      end else begin
         if (busS.rect_rd_en) begin
            check("read_in_query", 64'(active), 64'(1));
            check("read_addr", 64'(busS.rect_addr), 64'(readCnt));
            readCnt++;
         end
         if (busS.result_valid) begin
            check("valid_in_query", 64'(active), 64'(1));
            if (!seenResult) begin
               check("result_latency", 64'(cyc + 1 - t0), 64'(NR + 2));
               check("read_count", 64'(readCnt), 64'(NR));
               seenResult = 1'b1;
            end
            check("mask_strict", 64'(busS.result_mask), 64'(expS));
            check("hit_strict", 64'(busS.result_hit), 64'(|expS));
            check("idx_strict", 64'(busS.result_idx), 64'(lowestIdx(expS)));
            check("mask_incl", 64'(busI.result_mask), 64'(expI));
            check("idx_incl", 64'(busI.result_idx), 64'(lowestIdx(expI)));
            check("ready_low_done", 64'(busS.query_ready), 64'(0));
            if (busS.result_ready) active = 1'b0;
         end
         if (busS.query_valid && busS.query_ready) begin
            active = 1'b1;
            seenResult = 1'b0;
            t0 = cyc + 1;
            readCnt = 0;
            expS = modelMask(int'(busS.query_x), int'(busS.query_y), 1'b0);
            expI = modelMask(int'(busS.query_x), int'(busS.query_y), 1'b1);
         end
      end
   end

   task automatic setRect(input int i, input int bx, input int by, input int w, input int h);
      rBlX[i] = bx; rBlY[i] = by; rW[i] = w; rH[i] = h;
   endtask

   task automatic startQuery(input int x, input int y);
      int n = 0;
      @(posedge clock); #1;
      while (!busS.query_ready && n < 50) begin @(posedge clock); #1; n++; end
      check("ready_timeout", 64'(busS.query_ready), 64'(1));
      busS.query_x = CW'(x);
      busS.query_y = CW'(y);
      busS.query_valid = 1'b1;
      @(posedge clock); #1;
      busS.query_valid = 1'b0;
   endtask

   task automatic waitResult();
      int n = 0;
      while (!busS.result_valid && n < 50) begin @(posedge clock); #1; n++; end
      check("result_timeout", 64'(busS.result_valid), 64'(1));
   endtask

   task automatic runQuery(input int x, input int y, input int hold,
                           output logic [NR-1:0] m, output logic h, output logic [1:0] ix,
                           output logic [NR-1:0] mi);
      busS.result_ready = (hold == 0);
      startQuery(x, y);
      waitResult();
      m = busS.result_mask; h = busS.result_hit; ix = busS.result_idx; mi = busI.result_mask;
      repeat (hold) begin @(posedge clock); #1; end
      busS.result_ready = 1'b1;
      @(posedge clock); #1;
   endtask

   logic [NR-1:0] m, mi, held;
   logic h;
   logic [1:0] ix;

   initial begin
      resetn = 1'b0;
      busS.query_valid = 1'b0;
      busS.query_x = '0;
      busS.query_y = '0;
      busS.result_ready = 1'b1;
      setRect(0, 300, 300, 10, 10);
      setRect(1, 0, 0, 20, 20);
      setRect(2, 100, 100, 50, 50);
      setRect(3, 5, 5, 30, 30);
      repeat (2) @(posedge clock);
      #1;
      check("rst_query_ready", 64'(busS.query_ready), 64'(1));
      check("rst_rd_en", 64'(busS.rect_rd_en), 64'(0));
      check("rst_result_valid", 64'(busS.result_valid), 64'(0));
      check("rst_mask", 64'(busS.result_mask), 64'(0));
      resetn = 1'b1;

      runQuery(120, SH - 120, 0, m, h, ix, mi);
      check("lit_inside_mask", 64'(m), 64'(4'b0100));
      check("lit_inside_hit", 64'(h), 64'(1));
      check("lit_inside_idx", 64'(ix), 64'(2));
      runQuery(100, 380, 0, m, h, ix, mi);
      check("lit_edge_strict", 64'(h), 64'(0));
      check("lit_edge_incl", 64'(mi), 64'(4'b0100));
      runQuery(10, 470, 0, m, h, ix, mi);
      check("lit_overlap_mask", 64'(m), 64'(4'b1010));
      check("lit_overlap_idx", 64'(ix), 64'(1));
      runQuery(10, 500, 0, m, h, ix, mi);
      check("lit_offscreen_mask", 64'(m), 64'(0));
      check("lit_offscreen_incl", 64'(mi), 64'(0));
      runQuery(10, SH, 0, m, h, ix, mi);
      check("lit_y_screen_h_incl", 64'(mi), 64'(4'b0010));
      setRect(0, 16'hFFF0, 0, 16'h20, 16'hFFFF);
      runQuery(16'hFFFF, 240, 0, m, h, ix, mi);
      check("lit_no_wrap_mask", 64'(m), 64'(4'b0001));
      setRect(3, 50, 50, 0, 0);
      runQuery(50, SH - 50, 0, m, h, ix, mi);
      check("lit_zero_strict", 64'(m[3]), 64'(0));
      check("lit_zero_incl", 64'(mi[3]), 64'(1));

      // Backpressure: result held while a new query is offered.
      busS.result_ready = 1'b0;
      startQuery(120, SH - 120);
      waitResult();
      held = busS.result_mask;
      busS.query_x = CW'(10);
      busS.query_y = CW'(470);
      busS.query_valid = 1'b1;
      repeat (10) begin
         @(posedge clock); #1;
         check("bp_valid", 64'(busS.result_valid), 64'(1));
         check("bp_mask_stable", 64'(busS.result_mask), 64'(held));
         check("bp_query_ready", 64'(busS.query_ready), 64'(0));
         check("bp_no_read", 64'(busS.rect_rd_en), 64'(0));
      end
      busS.query_valid = 1'b0;
      busS.result_ready = 1'b1;
      @(posedge clock); #1;

      // Asynchronous reset in the middle of the scan.
      begin
         int n = 0;
         startQuery(10, 470);
         while (!(busS.rect_rd_en && busS.rect_addr == 2'd2) && n < 20) begin @(posedge clock); #1; n++; end
         check("reach_addr2", 64'(busS.rect_addr), 64'(2));
         #2 resetn = 1'b0;
         #1;
         check("arst_query_ready", 64'(busS.query_ready), 64'(1));
         check("arst_rd_en", 64'(busS.rect_rd_en), 64'(0));
         check("arst_addr", 64'(busS.rect_addr), 64'(0));
         check("arst_valid", 64'(busS.result_valid), 64'(0));
         check("arst_hit", 64'(busS.result_hit), 64'(0));
         check("arst_idx", 64'(busS.result_idx), 64'(0));
         check("arst_mask", 64'(busS.result_mask), 64'(0));
         @(posedge clock); #1;
         resetn = 1'b1;
      end
      setRect(0, 300, 300, 10, 10);
      setRect(3, 5, 5, 30, 30);
      runQuery(120, SH - 120, 0, m, h, ix, mi);
      check("post_rst_mask", 64'(m), 64'(4'b0100));

      for (int q = 0; q < 40; q++) begin
         int x, y, k;
         for (int i = 0; i < NR; i++)
            setRect(i, $urandom_range(0, 200), $urandom_range(0, 200),
                    ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 80),
                    ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 80));
         x = $urandom_range(0, 300);
         y = $urandom_range(0, 520);
         if ($urandom_range(0, 2) == 0) begin
            k = $urandom_range(0, NR - 1);
            x = rBlX[k] + ($urandom_range(0, 1) ? rW[k] : 0);
            y = SH - (rBlY[k] + ($urandom_range(0, 1) ? rH[k] : 0));
         end
         runQuery(x, y, $urandom_range(0, 3), m, h, ix, mi);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
